// File: rtl/uart_move_pkg.sv
// Shared types and word-field positions for the UART move receiver.
// Word layout: [15:14] opcode, [13:8] from, [7:2] to, [1:0] promo.
package uart_move_pkg;

  localparam int unsigned OpMsb    = 15;
  localparam int unsigned OpLsb    = 14;
  localparam int unsigned FromMsb  = 13;
  localparam int unsigned FromLsb  = 8;
  localparam int unsigned ToMsb    = 7;
  localparam int unsigned ToLsb    = 2;
  localparam int unsigned PromoMsb = 1;
  localparam int unsigned PromoLsb = 0;

  typedef enum logic [1:0] {
    OpMove     = 2'b00,
    OpAck      = 2'b01,
    OpResync   = 2'b10,
    OpReserved = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap
  } rd_state_e;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
    logic [1:0] promo;
  } move_t;

  // Takes the word with the opcode stripped, i.e. bits [13:0].
  function automatic move_t body_to_move(input logic [13:0] body);
    move_t m;
    m.from  = body[FromMsb:FromLsb];
    m.to    = body[ToMsb:ToLsb];
    m.promo = body[PromoMsb:PromoLsb];
    return m;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Circular buffer of decoded moves with synchronous flush.
// Pointers carry one extra bit so that full and empty can be told apart.
module move_fifo
  import uart_move_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  move_t push_data,
  input  logic  pop,
  input  logic  flush,
  output move_t head,
  output logic  valid,
  output logic  full
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  move_t          mem_q [FIFO_DEPTH];
  logic           empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Flush wins over any push or pop arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push && !flush) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
    end
  end

  assign valid = !empty;
  assign head  = valid ? mem_q[rd_ptr_q[AddrW-1:0]] : '0;

endmodule

// File: rtl/uart_move_rx.sv
// Pops words from a UART receiver, decodes move/ack/resync commands and
// buffers valid moves for a ready/valid consumer; bad words are counted.
module uart_move_rx
  import uart_move_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pending_data_rx,
  input  logic [DATA_WIDTH-1:0] data_out_rx,
  input  logic                  parity_error_rx,
  output logic                  req_data,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [5:0]            move_from,
  output logic [5:0]            move_to,
  output logic [1:0]            move_promo,
  output logic                  ack_pulse,
  output logic                  resync_pulse,
  output logic [7:0]            err_count,
  input  logic                  clr_err
);

  rd_state_e state_q;
  opcode_e   rx_op;
  move_t     rx_move, push_move_q, head;
  logic      rx_drop, push_q, err_inc_q, fifo_full;

  always_comb begin
    rx_op   = opcode_e'(data_out_rx[OpMsb:OpLsb]);
    rx_move = body_to_move(data_out_rx[FromMsb:PromoLsb]);
    rx_drop = parity_error_rx || (rx_op == OpReserved) ||
              ((rx_op == OpMove) && (rx_move.from == rx_move.to));
  end

  // Word is sampled at the end of StReq; its effects appear one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_data     <= 1'b0;
      push_q       <= 1'b0;
      push_move_q  <= '0;
      ack_pulse    <= 1'b0;
      resync_pulse <= 1'b0;
      err_inc_q    <= 1'b0;
    end else begin
      req_data     <= 1'b0;
      push_q       <= 1'b0;
      ack_pulse    <= 1'b0;
      resync_pulse <= 1'b0;
      err_inc_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pending_data_rx && !fifo_full) begin
            state_q  <= StReq;
            req_data <= 1'b1;
          end
        end
        StReq: begin
          state_q      <= StGap;
          push_q       <= !rx_drop && (rx_op == OpMove);
          push_move_q  <= rx_move;
          ack_pulse    <= !rx_drop && (rx_op == OpAck);
          resync_pulse <= !rx_drop && (rx_op == OpResync);
          err_inc_q    <= rx_drop;
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (err_inc_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  move_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .push_data(push_move_q),
    .pop      (move_ready),
    .flush    (resync_pulse),
    .head     (head),
    .valid    (move_valid),
    .full     (fifo_full)
  );

  assign move_from  = head.from;
  assign move_to    = head.to;
  assign move_promo = head.promo;

endmodule

// File: tb/tb_uart_move_rx.sv
// Bench for uart_move_rx: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the word stream.
module tb_uart_move_rx;

  localparam int Depth   = 4;
  localparam int KNone   = 0;
  localparam int KPush   = 1;
  localparam int KAck    = 2;
  localparam int KResync = 3;
  localparam int KDrop   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pending_data_rx = 1'b0;
  logic [15:0] data_out_rx = 16'h0;
  logic        parity_error_rx = 1'b0;
  logic        req_data;
  logic        move_valid;
  logic        move_ready = 1'b0;
  logic [5:0]  move_from, move_to;
  logic [1:0]  move_promo;
  logic        ack_pulse, resync_pulse;
  logic [7:0]  err_count;
  logic        clr_err = 1'b0;

  int n_assert = 0;
  int n_fail = 0;
  int uart_q[$];   // parity * 65536 + word
  int model_q[$];  // 14-bit move body, in consumer order
  int pend_kind = KNone;
  int pend_body = 0;
  int exp_err = 0;
  int cyc = 0;
  int last_req = -10;
  int n_req = 0;
  int n_resync = 0;

  always #5 clk = ~clk;

  uart_move_rx #(
    .FIFO_DEPTH(Depth),
    .DATA_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pending_data_rx(pending_data_rx),
    .data_out_rx    (data_out_rx),
    .parity_error_rx(parity_error_rx),
    .req_data       (req_data),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .move_from      (move_from),
    .move_to        (move_to),
    .move_promo     (move_promo),
    .ack_pulse      (ack_pulse),
    .resync_pulse   (resync_pulse),
    .err_count      (err_count),
    .clr_err        (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int w, input int par);
    int op, fr, to;
    op = w / 16384;
    fr = (w / 256) % 64;
    to = (w / 4) % 64;
    if (par != 0 || op == 3) return KDrop;
    if (op == 1) return KAck;
    if (op == 2) return KResync;
    if (fr == to) return KDrop;
    return KPush;
  endfunction

  function automatic int mk_move(input int fr, input int to, input int pr);
    return fr * 256 + to * 4 + pr;
  endfunction

  task automatic drive_uart();
    if (uart_q.size() > 0) begin
      pending_data_rx = 1'b1;
      data_out_rx     = 16'(uart_q[0] % 65536);
      parity_error_rx = (uart_q[0] / 65536) != 0;
    end else begin
      pending_data_rx = 1'b0;
      data_out_rx     = 16'h0;
      parity_error_rx = 1'b0;
    end
  endtask

  task automatic send(input int w, input int par);
    uart_q.push_back(par * 65536 + w);
    drive_uart();
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick();
    int  ef, et, ep, w;
    bit  hs, req;
    ef = 0; et = 0; ep = 0; w = 0;
    if (model_q.size() > 0) begin
      ef = (model_q[0] / 256) % 64;
      et = (model_q[0] / 4) % 64;
      ep = model_q[0] % 4;
    end
    chk("move_valid", move_valid, model_q.size() > 0);
    chk("move_from", move_from, ef);
    chk("move_to", move_to, et);
    chk("move_promo", move_promo, ep);
    chk("ack_pulse", ack_pulse, pend_kind == KAck);
    chk("resync_pulse", resync_pulse, pend_kind == KResync);
    chk("err_count", err_count, exp_err);
    if (req_data) begin
      chk("req_has_word", uart_q.size() > 0, 1);
      chk("req_not_full", model_q.size() < Depth, 1);
      chk("req_spacing", (cyc - last_req) >= 3, 1);
      last_req = cyc;
      n_req++;
    end
    if (resync_pulse) n_resync++;
    hs  = (model_q.size() > 0) && move_ready;
    req = req_data;
    @(posedge clk);
    #1;
    cyc++;
    if (req && uart_q.size() > 0) w = uart_q.pop_front();
    if (!rst_n) begin
      model_q.delete();
      pend_kind = KNone;
      exp_err   = 0;
      last_req  = -10;
    end else begin
      if (pend_kind == KResync) begin
        model_q.delete();
      end else begin
        if (hs) void'(model_q.pop_front());
        if (pend_kind == KPush) model_q.push_back(pend_body);
      end
      if (clr_err) exp_err = 0;
      else if (pend_kind == KDrop && exp_err < 255) exp_err++;
      pend_kind = req ? classify(w % 65536, w / 65536) : KNone;
      pend_body = (w % 65536) % 16384;
    end
    drive_uart();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input int budget);
    int k;
    k = 0;
    while (!req_data && k < budget) begin
      tick();
      k++;
    end
    chk("wait_req", req_data, 1);
  endtask

  initial begin
    int r0, s0, w, op, fr, to;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_data", req_data, 0);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_move_from", move_from, 0);
    chk("rst_ack", ack_pulse, 0);
    chk("rst_resync", resync_pulse, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    run(2);

    // Single move: visible two cycles after the pop strobe.
    send(16'h0A3C, 0);
    wait_req(20);
    tick();
    tick();
    chk("single_valid", move_valid, 1);
    chk("single_from", move_from, 10);
    chk("single_to", move_to, 15);
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    run(2);

    // Five moves into a four-deep buffer: fifth waits in the UART.
    r0 = n_req;
    for (int i = 0; i < 5; i++) send(mk_move(i + 1, i + 20, i % 4), 0);
    run(40);
    chk("bp_reads", n_req - r0, 4);
    chk("bp_pending", uart_q.size(), 1);
    chk("bp_pending_pin", pending_data_rx, 1);
    chk("bp_head_from", move_from, 1);
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    run(20);
    chk("bp_fifth_read", n_req - r0, 5);
    chk("bp_uart_empty", uart_q.size(), 0);
    chk("bp_head_from2", move_from, 2);
    move_ready = 1'b1;
    run(20);
    move_ready = 1'b0;
    chk("bp_drained", move_valid, 0);

    // Three kinds of bad word.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    send(16'h1234, 1);
    send(16'hC000, 0);
    send(mk_move(5, 5, 0), 0);
    run(20);
    chk("drop_err_count", err_count, 3);
    chk("drop_no_valid", move_valid, 0);

    // Resync flushes the buffer even with a pop on the same edge.
    s0 = n_resync;
    for (int i = 0; i < 3; i++) send(mk_move(30 + i, 40 + i, 1), 0);
    run(20);
    chk("rs_buffered", move_valid, 1);
    send(16'h8000, 0);
    wait_req(20);
    tick();
    chk("rs_pulse", resync_pulse, 1);
    move_ready = 1'b1;
    tick();
    chk("rs_flushed", move_valid, 0);
    tick();
    chk("rs_still_empty", move_valid, 0);
    move_ready = 1'b0;
    run(5);
    chk("rs_one_pulse", n_resync - s0, 1);

    // Error counter saturation and clear-over-increment.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int i = 0; i < 260; i++) send(int'($urandom_range(0, 65535)), 1);
    run(260 * 3 + 20);
    chk("sat_err", err_count, 255);
    send(16'h4000, 1);
    wait_req(20);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_priority", err_count, 0);

    // Reset during the pop cycle abandons the word.
    send(16'h0A3C, 0);
    wait_req(20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rreq_req_data", req_data, 0);
    chk("rreq_valid", move_valid, 0);
    chk("rreq_from", move_from, 0);
    chk("rreq_ack", ack_pulse, 0);
    chk("rreq_err", err_count, 0);
    run(10);
    chk("rreq_no_write", move_valid, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if (uart_q.size() < 6 && $urandom_range(0, 3) == 0) begin
        op = int'($urandom_range(0, 9));
        fr = int'($urandom_range(0, 63));
        to = ($urandom_range(0, 9) == 0) ? fr : int'($urandom_range(0, 63));
        w  = mk_move(fr, to, int'($urandom_range(0, 3)));
        if (op >= 6 && op <= 7) w = w + 16384;
        else if (op == 8) w = w + 2 * 16384;
        else if (op == 9) w = w + 3 * 16384;
        send(w, ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
      move_ready = ($urandom_range(0, 2) != 0);
      clr_err    = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr_err    = 1'b0;
    move_ready = 1'b1;
    run(80);
    chk("rand_drained", move_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_move_rx.md
UART_MOVE_RX -- requirements
Module: uart_move_rx

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 4, giving the number of buffered decoded moves (power of two, at least 2).
REQ-002 The block SHALL have a parameter DATA_WIDTH, default 16, giving the UART word width; only 16 is supported.
REQ-003 Port clk, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port pending_data_rx, input, 1 bit: the UART holds an unread received word.
REQ-006 Port data_out_rx, input, 16 bits: the UART received word; valid in the cycle req_data is high.
REQ-007 Port parity_error_rx, input, 1 bit: parity error flag for data_out_rx; valid in the cycle req_data is high.
REQ-008 Port req_data, output, 1 bit: one-cycle pop strobe to the UART.
REQ-009 Port move_valid, output, 1 bit: the FIFO head holds a decoded move.
REQ-010 Port move_ready, input, 1 bit: the consumer accepts the head move.
REQ-011 Port move_from, output, 6 bits: source square of the head move (0..63).
REQ-012 Port move_to, output, 6 bits: destination square of the head move.
REQ-013 Port move_promo, output, 2 bits: promotion code of the head move.
REQ-014 Port ack_pulse, output, 1 bit: one-cycle pulse for each accepted ACK word.
REQ-015 Port resync_pulse, output, 1 bit: one-cycle pulse for each accepted RESYNC word.
REQ-016 Port err_count, output, 8 bits: count of dropped words; saturates at 255.
REQ-017 Port clr_err, input, 1 bit: synchronous clear of err_count.

Function
REQ-018 Word format SHALL be [15:14] opcode (00 MOVE, 01 ACK, 10 RESYNC, 11 RESERVED), [13:8] from, [7:2] to, [1:0] promo.
REQ-019 The read FSM SHALL have three states: IDLE, REQ and GAP.
REQ-020 IDLE SHALL go to REQ when pending_data_rx=1 and the registered FIFO full flag=0; otherwise it SHALL stay in IDLE.
REQ-021 REQ SHALL drive req_data=1 for exactly one cycle, capture data_out_rx and parity_error_rx in that cycle, then go to GAP.
REQ-022 GAP SHALL last one cycle with req_data=0, then return to IDLE, so back-to-back pops are at least 3 cycles apart.
REQ-023 A word captured with a parity error SHALL be dropped and SHALL increment err_count.
REQ-024 A word with the RESERVED opcode SHALL be dropped and SHALL increment err_count.
REQ-025 A MOVE word with from==to SHALL be dropped and SHALL increment err_count.
REQ-026 A valid MOVE word captured in cycle N SHALL be written to the FIFO in cycle N+1; if the FIFO was empty, move_valid SHALL be 1 in cycle N+2.
REQ-027 ACK SHALL pulse ack_pulse in cycle N+1; RESYNC SHALL pulse resync_pulse in cycle N+1 and flush the FIFO in the same edge.
REQ-028 A flush SHALL take priority over a simultaneous push or pop; move_valid SHALL be 0 in the cycle after the flush.
REQ-029 A pop SHALL occur on each cycle with move_valid=1 and move_ready=1; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-031 move_from, move_to and move_promo SHALL be 0 whenever move_valid=0.
REQ-032 err_count SHALL hold at 255 once reached; clr_err SHALL take priority over a simultaneous increment and yield 0.
REQ-033 When the FIFO is full, no req_data SHALL be issued and the word SHALL remain pending in the UART (back-pressure, no loss).

Reset
REQ-034 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the FIFO SHALL empty, and err_count, req_data, move_valid, ack_pulse, resync_pulse and all move fields SHALL become 0.
REQ-035 Reset in REQ or GAP SHALL abandon the in-flight word with no FIFO write and no pulse.

Structure
REQ-036 Package uart_move_pkg SHALL hold the opcode enum, the move_t struct (from, to, promo) and the bit-position constants.
REQ-037 The buffer SHALL be a sub-module move_fifo, parameterised by FIFO_DEPTH, storing move_t and providing a flush input.

Verification
REQ-038 Single MOVE 16'h0A3C (from=10, to=15, promo=0) -> one req_data pulse; move_valid=1 two cycles after that pulse, move_from=10, move_to=15.
REQ-039 Five MOVEs with move_ready=0 and FIFO_DEPTH=4 -> four stored, fifth left pending with no req_data; one pop -> fifth read; outputs in FIFO order.
REQ-040 Parity-error word, then RESERVED 16'hC000, then MOVE from=to=5 -> all three dropped, err_count=3, move_valid stays 0.
REQ-041 Three MOVEs buffered, then RESYNC 16'h8000 -> one resync_pulse and FIFO emptied; a simultaneous move_ready pop causes no underflow.
REQ-042 260 parity errors -> err_count=255; clr_err asserted with an error in the same cycle -> err_count=0.
REQ-043 rst_n=0 asserted in the REQ cycle -> no FIFO write and all outputs 0 on the next edge.
